// File: rtl/gpio_aux_edge_irq.sv
// Per-bit selectable edge detector with sticky W1C status, level irq and saturating event counter.
// Latency: status sets on the edge that samples the change (plus DEBOUNCE_CYCLES when filtered); irq one edge later.
// No backpressure: every cycle is processed; optional input debounce is enabled by defining GPIO_AUX_DEBOUNCE_EN.
module gpio_aux_edge_irq #(
    parameter int WIDTH           = 32,
    parameter int CNT_W           = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [WIDTH-1:0] aux_i,
    input  logic [WIDTH-1:0] edge_pos,
    input  logic [WIDTH-1:0] edge_neg,
    input  logic [WIDTH-1:0] int_en,
    input  logic             sts_clr_we,
    input  logic [WIDTH-1:0] sts_clr_data,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] int_status,
    output logic             irq,
    output logic [CNT_W-1:0] evt_cnt
);

    // A zero-length debounce window would never let the filtered value move.
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be >= 1");
    end

    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] prev;
    logic             armed;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] evt;
    logic [WIDTH-1:0] clr_mask;
    logic             evt_any;

`ifdef GPIO_AUX_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [WIDTH-1:0] dbn;
    logic [DW-1:0]    dcnt [WIDTH];

    // Filtered value follows aux_i only after it has differed for DEBOUNCE_CYCLES consecutive samples.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            dbn <= '0;
            for (int b = 0; b < WIDTH; b++) begin
                dcnt[b] <= '0;
            end
        end else begin
            for (int b = 0; b < WIDTH; b++) begin
                if (aux_i[b] == dbn[b]) begin
                    dcnt[b] <= '0;
                end else if (dcnt[b] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    dbn[b]  <= aux_i[b];
                    dcnt[b] <= '0;
                end else begin
                    dcnt[b] <= dcnt[b] + DW'(1);
                end
            end
        end
    end

    assign filt = dbn;
`else
    assign filt = aux_i;
`endif

    // Edge classification against the previous filtered sample; suppressed on the arming edge.
    always_comb begin
        rise     = filt & ~prev;
        fall     = ~filt & prev;
        evt      = '0;
        if (armed) begin
            evt = (rise & edge_pos) | (fall & edge_neg);
        end
        clr_mask = sts_clr_we ? sts_clr_data : '0;
        evt_any  = |evt;
    end

    // History register and arming flag; the first edge after reset only captures the current level.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            prev  <= '0;
            armed <= 1'b0;
        end else begin
            prev  <= filt;
            armed <= 1'b1;
        end
    end

    // Sticky status with write-1-to-clear; a new event on the same bit beats the clear.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            int_status <= '0;
        end else begin
            int_status <= (int_status & ~clr_mask) | evt;
        end
    end

    // Interrupt is built from registered status, so it trails status by one edge.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            irq <= 1'b0;
        end else begin
            irq <= |(int_status & int_en);
        end
    end

    // One count per cycle with any event; clear wins over increment, holds at all-ones.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            evt_cnt <= '0;
        end else if (cnt_clr) begin
            evt_cnt <= '0;
        end else if (evt_any && (evt_cnt != {CNT_W{1'b1}})) begin
            evt_cnt <= evt_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_gpio_aux_edge_irq.sv
// Directed self-checking bench for gpio_aux_edge_irq (CNT_W=4 to reach saturation quickly).
// Inputs change 1ns after the rising edge; outputs are checked at that same point, away from the edge.
// Debounce-specific scenarios run only when GPIO_AUX_DEBOUNCE_EN is defined.
module tb_gpio_aux_edge_irq;

    localparam int W   = 32;
    localparam int CW  = 4;
`ifdef GPIO_AUX_DEBOUNCE_EN
    localparam int DB  = 4;
`else
    localparam int DB  = 0;
`endif

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic [W-1:0]  aux_i;
    logic [W-1:0]  edge_pos;
    logic [W-1:0]  edge_neg;
    logic [W-1:0]  int_en;
    logic          sts_clr_we;
    logic [W-1:0]  sts_clr_data;
    logic          cnt_clr;
    logic [W-1:0]  int_status;
    logic          irq;
    logic [CW-1:0] evt_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    gpio_aux_edge_irq #(
        .WIDTH(W),
        .CNT_W(CW),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .aux_i(aux_i),
        .edge_pos(edge_pos),
        .edge_neg(edge_neg),
        .int_en(int_en),
        .sts_clr_we(sts_clr_we),
        .sts_clr_data(sts_clr_data),
        .cnt_clr(cnt_clr),
        .int_status(int_status),
        .irq(irq),
        .evt_cnt(evt_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    // Clear all status and the counter in one cycle, with no edges enabled.
    task automatic wipe();
        sts_clr_we   = 1'b1;
        sts_clr_data = '1;
        cnt_clr      = 1'b1;
        tick();
        sts_clr_we   = 1'b0;
        sts_clr_data = '0;
        cnt_clr      = 1'b0;
    endtask

    initial begin
        sys_rst      = 1'b1;
        aux_i        = 32'hFFFF_FFFF;
        edge_pos     = (DB == 0) ? 32'hFFFF_FFFF : 32'h0;
        edge_neg     = '0;
        int_en       = '0;
        sts_clr_we   = 1'b0;
        sts_clr_data = '0;
        cnt_clr      = 1'b0;
        tick(2);
        chk("rst_status", int_status, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        chk("rst_cnt", {28'b0, evt_cnt}, 32'h0);

        // Release with inputs already high: arming must not report a rising edge.
        sys_rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("arm_status", int_status, 32'h0);
            chk("arm_irq", {31'b0, irq}, 32'h0);
        end
        chk("arm_cnt", {28'b0, evt_cnt}, 32'h0);

        // Rising edges on the low byte only.
        edge_pos = '0;
        aux_i    = '0;
        tick(DB + 2);
        wipe();
        edge_pos = 32'h0000_00FF;
        int_en   = 32'h0000_0001;
        aux_i    = 32'hA5A5_A5A5;
        tick(DB + 1);
        chk("rise_status", int_status, 32'h0000_00A5);
        chk("rise_irq_lag", {31'b0, irq}, 32'h0);
        chk("rise_cnt", {28'b0, evt_cnt}, 32'h1);
        tick();
        chk("rise_irq_bit0", {31'b0, irq}, 32'h1);
        int_en = 32'h0000_0002;
        tick();
        chk("mask_irq_bit1", {31'b0, irq}, 32'h0);
        int_en = 32'h0000_0004;
        tick();
        chk("en_irq_bit2", {31'b0, irq}, 32'h1);
        chk("en_status_held", int_status, 32'h0000_00A5);

        // Falling edges on every bit, then a partial W1C.
        edge_pos = '0;
        int_en   = '0;
        aux_i    = 32'h5A5A_5A5A;
        tick(DB + 2);
        wipe();
        edge_neg = '1;
        aux_i    = '0;
        tick(DB + 1);
        chk("fall_status", int_status, 32'h5A5A_5A5A);
        chk("fall_cnt", {28'b0, evt_cnt}, 32'h1);
        sts_clr_we   = 1'b1;
        sts_clr_data = 32'h0000_005A;
        tick();
        sts_clr_we   = 1'b0;
        sts_clr_data = '0;
        chk("w1c_status", int_status, 32'h5A5A_5A00);

        // Set and clear on bit 3 in the same cycle: set wins.
        wipe();
        edge_pos = '1;
        aux_i    = 32'h0000_0008;
        tick(DB);
        sts_clr_we   = 1'b1;
        sts_clr_data = 32'h0000_0008;
        tick();
        sts_clr_we   = 1'b0;
        sts_clr_data = '0;
        chk("setwin_status", int_status, 32'h0000_0008);
        chk("setwin_cnt", {28'b0, evt_cnt}, 32'h1);

        // Counter clear on an event cycle drops that event.
        aux_i = '0;
        tick(DB);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("cntclr_cnt", {28'b0, evt_cnt}, 32'h0);
        chk("cntclr_status", int_status, 32'h0000_0008);

        // Saturation with both edges on bit 0.
        wipe();
        for (int i = 0; i < 20; i++) begin
            aux_i[0] = ~aux_i[0];
            tick(DB + 1);
            if (i == 13) chk("cnt_14", {28'b0, evt_cnt}, 32'd14);
            if (i == 14) chk("cnt_15", {28'b0, evt_cnt}, 32'd15);
        end
        chk("cnt_sat", {28'b0, evt_cnt}, 32'd15);
        int_en = '1;
        tick();
        chk("pre_rst_irq", {31'b0, irq}, 32'h1);

        // Reset mid-activity.
        aux_i[0] = ~aux_i[0];
        tick();
        sys_rst = 1'b1;
        tick();
        chk("midrst_status", int_status, 32'h0);
        chk("midrst_irq", {31'b0, irq}, 32'h0);
        chk("midrst_cnt", {28'b0, evt_cnt}, 32'h0);

`ifndef GPIO_AUX_DEBOUNCE_EN
        // One-cycle pulse with both edges enabled: two event cycles.
        aux_i    = '0;
        edge_pos = 32'h0000_0010;
        edge_neg = 32'h0000_0010;
        tick();
        sys_rst = 1'b0;
        tick(2);
        aux_i = 32'h0000_0010;
        tick();
        aux_i = '0;
        chk("pulse_rise_cnt", {28'b0, evt_cnt}, 32'd1);
        tick();
        chk("pulse_fall_cnt", {28'b0, evt_cnt}, 32'd2);
        chk("pulse_status", int_status, 32'h0000_0010);
`else
        // Glitch rejection and debounce latency on bit 0.
        aux_i    = '0;
        edge_pos = 32'h0000_0001;
        edge_neg = '0;
        int_en   = '0;
        tick();
        sys_rst = 1'b0;
        tick(6);
        aux_i = 32'h1;
        tick(3);
        aux_i = '0;
        tick(6);
        chk("glitch_status", int_status, 32'h0);
        chk("glitch_cnt", {28'b0, evt_cnt}, 32'h0);
        aux_i = 32'h1;
        tick(4);
        chk("dbn_wait_status", int_status, 32'h0);
        tick();
        chk("dbn_status", int_status, 32'h1);
        tick();
        aux_i = '0;
        tick(6);
        chk("dbn_cnt", {28'b0, evt_cnt}, 32'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
